// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side arbiter: FSM encodings and width helper.
package fifo_pkg;

  localparam int unsigned STATE_W = 1;

  // Arbiter FSM encodings
  localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [STATE_W-1:0] ST_BURST = 1'b1;

  // clog2 that never returns 0, so a single-entry parameter still yields a 1-bit field
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after rr_ptr_i, wrapping.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = clog2w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] win_oh_c,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               win_any_c
);

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ); the last visited index is rr_ptr itself
  always_comb begin : pick
    int unsigned        cand;
    logic [IDX_W-1:0]   cidx;
    win_oh_c  = '0;
    win_idx_c = '0;
    win_any_c = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr_i) + k) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!win_any_c && req_i[cidx]) begin
        win_any_c = 1'b1;
        win_idx_c = cidx;
      end
    end
    win_oh_c[win_idx_c] = win_any_c;
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares one FIFO read port among NUM_REQ requesters with round-robin bursts of up to
// MAX_BURST pops, one idle turnaround cycle between grants.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        rd_clk,
  input  logic                        rd_rst_n,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        fifo_empty,
  input  logic [DATA_SIZE-1:0]        fifo_rd_data,
  output logic                        fifo_rd_en,
  output logic [DATA_SIZE-1:0]        out_data,
  output logic                        out_valid,
  output logic [clog2w(NUM_REQ)-1:0]  out_id
);

  localparam int unsigned IDX_W = clog2w(NUM_REQ);
  localparam int unsigned CNT_W = clog2w(MAX_BURST) + 1;

  logic [STATE_W-1:0]   state_q,     state_d;
  logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [DATA_SIZE-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0]     out_id_q,    out_id_d;
  logic                 out_valid_q, out_valid_d;

  logic [NUM_REQ-1:0]   win_oh_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 win_any_c;
  logic                 pop_c;
  logic [CNT_W-1:0]     cnt_inc_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .win_oh_c  (win_oh_c),
    .win_idx_c (win_idx_c),
    .win_any_c (win_any_c)
  );

  // Pop strobe; rr_ptr_q holds the granted index for the whole burst
  always_comb begin : pop_logic
    pop_c = (state_q == ST_BURST) && req[rr_ptr_q] && !fifo_empty
            && (cnt_q < CNT_W'(MAX_BURST));
    cnt_inc_c = cnt_q + CNT_W'(1);
  end

  // Next-state and output-register next values
  always_comb begin : next_state
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (win_any_c && !fifo_empty) begin
        state_d  = ST_BURST;
        gnt_d    = win_oh_c;
        rr_ptr_d = win_idx_c;
        cnt_d    = '0;
      end
    end else begin
      if (pop_c) begin
        out_data_d  = fifo_rd_data;
        out_id_d    = rr_ptr_q;
        out_valid_d = 1'b1;
        cnt_d       = cnt_inc_c;
      end
      // Leave on burst limit, owner dropping its request, or the FIFO running dry
      if ((pop_c && (cnt_inc_c == CNT_W'(MAX_BURST))) || !req[rr_ptr_q] || fifo_empty) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
  end

  // State and output registers; rr_ptr resets to the last index so requester 0 wins first
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin : regs
    if (!rd_rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt        = gnt_q;
  assign fifo_rd_en = pop_c;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a small pointer-based FIFO model.
module tb_fifo_rd_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_SIZE = 4;
  localparam int unsigned MAX_BURST = 4;

  logic                 rd_clk = 1'b0;
  logic                 rd_rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ-1:0]   gnt;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_rd_data;
  logic                 fifo_rd_en;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic [1:0]           out_id;

  // FIFO model: pops advance rd_ptr on the clock, words are pushed by the test tasks
  logic [DATA_SIZE-1:0] mem [256];
  logic [7:0]           rd_ptr = 8'd0;
  logic [7:0]           wr_ptr = 8'd0;
  logic                 flush  = 1'b0;

  int total = 0;
  int bad   = 0;
  int log_n = 0;
  logic [DATA_SIZE-1:0] log_data [64];
  logic [1:0]           log_id   [64];

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  fifo_rd_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_SIZE (DATA_SIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .req          (req),
    .gnt          (gnt),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_id       (out_id)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
  end

  // Advance to the next falling edge, check invariants, log any output word
  task automatic tick();
    @(negedge rd_clk);
    total++;
    if ((fifo_rd_en && fifo_empty) || !$onehot0(gnt)) begin
      bad++;
      $display("FAIL invariant @%0t: gnt=%b rd_en=%b empty=%b, want one-hot0 gnt and no pop while empty",
               $time, gnt, fifo_rd_en, fifo_empty);
    end
    if (out_valid && log_n < 64) begin
      log_data[log_n] = out_data;
      log_id[log_n]   = out_id;
      log_n++;
    end
  endtask

  task automatic push(input logic [DATA_SIZE-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic do_flush();
    req   = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic apply_reset();
    req      = '0;
    rd_rst_n = 1'b0;
    tick();
    tick();
    rd_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0;
    req      = '0;
    #3;
    total++;
    if (gnt !== 4'b0000 || out_valid !== 1'b0 || out_data !== 4'h0 || out_id !== 2'd0 || fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: gnt=%b ov=%b od=%h id=%0d rd_en=%b, want all 0",
               gnt, out_valid, out_data, out_id, fifo_rd_en);
    end
    tick();
    rd_rst_n = 1'b1;
    for (int w = 1; w <= 6; w++) push(DATA_SIZE'(w));
    req = 4'b0001;
    tick();
    total++;
    if (gnt !== 4'b0001 || fifo_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: gnt=%b rd_en=%b, want 0001 1", gnt, fifo_rd_en);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h1 || fifo_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_pop: ov=%b od=%h rd_en=%b, want 1 1 1", out_valid, out_data, fifo_rd_en);
    end
    #2 rd_rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0000 || fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_burst: gnt=%b rd_en=%b ov=%b, want 0000 0 0", gnt, fifo_rd_en, out_valid);
    end
    tick();
    rd_rst_n = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_regrant: gnt=%b, want 0001", gnt);
    end
    req = '0;
    tick();
    tick();
    do_flush();
  endtask

  task automatic test_single();
    logic [3:0] exp_gnt [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    logic       exp_ov  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int base;
    for (int w = 1; w <= 6; w++) push(DATA_SIZE'(w));
    base = log_n;
    req  = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (gnt !== exp_gnt[i] || out_valid !== exp_ov[i]) begin
        bad++;
        $display("FAIL single_cycle[%0d]: gnt=%b ov=%b, want %b %b", i, gnt, out_valid, exp_gnt[i], exp_ov[i]);
      end
    end
    req = '0;
    total++;
    if (log_n - base !== 6) begin
      bad++;
      $display("FAIL single_count: got %0d words, want 6", log_n - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_data[base+i] !== DATA_SIZE'(i + 1) || log_id[base+i] !== 2'd0) begin
          bad++;
          $display("FAIL single_word[%0d]: data=%h id=%0d, want %h 0", i, log_data[base+i], log_id[base+i], i + 1);
        end
      end
    end
    do_flush();
  endtask

  task automatic test_contention();
    logic [3:0] exp_gnt [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    int base;
    apply_reset();
    for (int w = 1; w <= 8; w++) push(DATA_SIZE'(w));
    base = log_n;
    req  = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (gnt !== exp_gnt[i]) begin
        bad++;
        $display("FAIL contention_gnt[%0d]: gnt=%b, want %b", i, gnt, exp_gnt[i]);
      end
    end
    push(4'h9);
    push(4'hA);
    tick();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL contention_next_grant: gnt=%b, want 0100", gnt);
    end
    req = '0;
    tick();
    tick();
    total++;
    if (log_n - base !== 8) begin
      bad++;
      $display("FAIL contention_count: got %0d words, want 8", log_n - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (log_data[base+i] !== DATA_SIZE'(i + 1) || log_id[base+i] !== 2'(i / 4)) begin
          bad++;
          $display("FAIL contention_word[%0d]: data=%h id=%0d, want %h %0d",
                   i, log_data[base+i], log_id[base+i], i + 1, i / 4);
        end
      end
    end
    do_flush();
  endtask

  task automatic test_drop();
    int base;
    for (int w = 1; w <= 6; w++) push(DATA_SIZE'(w));
    base = log_n;
    req  = 4'b0100;
    tick();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL drop_grant: gnt=%b, want 0100", gnt);
    end
    tick();
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h2 || out_id !== 2'd2) begin
      bad++;
      $display("FAIL drop_second_pop: ov=%b od=%h id=%0d, want 1 2 2", out_valid, out_data, out_id);
    end
    req = '0;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL drop_rd_en_comb: rd_en=%b, want 0", fifo_rd_en);
    end
    tick();
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL drop_idle: gnt=%b, want 0000", gnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL drop_quiet[%0d]: rd_en=%b ov=%b, want 0 0", i, fifo_rd_en, out_valid);
      end
    end
    total++;
    if (log_n - base !== 2 || log_data[base] !== 4'h1 || log_data[base+1] !== 4'h2) begin
      bad++;
      $display("FAIL drop_words: count=%0d first=%h second=%h, want 2 1 2",
               log_n - base, log_data[base], log_data[base+1]);
    end
    do_flush();
  endtask

  task automatic test_empty();
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (gnt !== 4'b0000 || fifo_rd_en !== 1'b0) begin
        bad++;
        $display("FAIL empty_hold[%0d]: gnt=%b rd_en=%b, want 0000 0", i, gnt, fifo_rd_en);
      end
    end
    push(4'h7);
    tick();
    total++;
    if (gnt !== 4'b0001 || fifo_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL empty_release: gnt=%b rd_en=%b, want 0001 1", gnt, fifo_rd_en);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h7 || out_id !== 2'd0 || fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL empty_pop: ov=%b od=%h id=%0d rd_en=%b, want 1 7 0 0",
               out_valid, out_data, out_id, fifo_rd_en);
    end
    tick();
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL empty_back_idle: gnt=%b, want 0000", gnt);
    end
    req = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_drop();
    test_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
